mig_wr_engine: RTL



---
 rtl/mig_pkg.sv | 16 +
 rtl/mig_addr_gen.sv | 42 ++++
 rtl/mig_wr_engine.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mig_pkg.sv
// Shared MIG UI definitions for the read and write engines.
package mig_pkg;

    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    localparam int unsigned MIG_DATA_W    = 128;
    localparam int unsigned MIG_ADDR_STEP = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } eng_state_e;

endpackage

// File: rtl/mig_addr_gen.sv
// Burst address generator: load, step by ADDR_STEP, optional wrap to cfg_base past cfg_top.
module mig_addr_gen #(
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned ADDR_STEP = 8,
    parameter int unsigned WRAP_EN   = 0
) (
    input  logic              ui_clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              step,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_top,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;

    // A start address outside the region is kept; wrap only triggers once addr reaches cfg_top.
    always_comb begin
        addr_next = addr_q + STEP;
        if ((WRAP_EN != 0) && (addr_q >= cfg_top)) begin
            addr_next = cfg_base;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= load_addr;
        end else if (step) begin
            addr_q <= addr_next;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/mig_wr_engine.sv
// MIG UI write engine: issues one BL8 write burst per word, data may lead commands by MAX_LEAD.
module mig_wr_engine
    import mig_pkg::*;
#(
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned DATA_W    = MIG_DATA_W,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned ADDR_STEP = MIG_ADDR_STEP,
    parameter int unsigned MAX_LEAD  = 2,
    parameter int unsigned WRAP_EN   = 0
) (
    input  logic                  ui_clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [ADDR_W-1:0]     wr_req_addr,
    input  logic [LEN_W-1:0]      wr_length,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [ADDR_W-1:0]     cfg_top,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_mask,
    output logic                  wr_data_valid,
    output logic                  wr_busy,
    output logic                  wr_done,
    output logic [ADDR_W-1:0]     app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [DATA_W-1:0]     app_wdf_data,
    output logic [DATA_W/8-1:0]   app_wdf_mask,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy
);

    localparam logic [LEN_W-1:0] LEAD_LIM = LEN_W'(MAX_LEAD);

    eng_state_e       state_q;
    eng_state_e       state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cmd_cnt;
    logic [LEN_W-1:0] dat_cnt;
    logic [LEN_W-1:0] lead;
    logic             start;
    logic             dat_go;
    logic             cmd_fire;
    logic             last_cmd;

    assign start    = (state_q == IDLE) && wr_req && (wr_length != '0);
    assign lead     = dat_cnt - cmd_cnt;
    assign cmd_fire = app_en && app_rdy;
    assign last_cmd = cmd_fire && (cmd_cnt == len_q - LEN_W'(1));

    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = (wr_length != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_cmd) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A command may go out in the same cycle as its own data word, never earlier.
    always_comb begin
        wr_busy = 1'b0;
        wr_done = 1'b0;
        dat_go  = 1'b0;
        app_en  = 1'b0;
        case (state_q)
            RUN: begin
                wr_busy = 1'b1;
                dat_go  = app_wdf_rdy && (dat_cnt < len_q) && (lead < LEAD_LIM);
                app_en  = (cmd_cnt < len_q) && ((cmd_cnt < dat_cnt) || dat_go);
            end
            DONE:    wr_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            len_q   <= '0;
            cmd_cnt <= '0;
            dat_cnt <= '0;
        end else if (start) begin
            len_q   <= wr_length;
            cmd_cnt <= '0;
            dat_cnt <= '0;
        end else begin
            if (dat_go) begin
                dat_cnt <= dat_cnt + LEN_W'(1);
            end
            if (cmd_fire) begin
                cmd_cnt <= cmd_cnt + LEN_W'(1);
            end
        end
    end

    mig_addr_gen #(
        .ADDR_W    (ADDR_W),
        .ADDR_STEP (ADDR_STEP),
        .WRAP_EN   (WRAP_EN)
    ) u_addr_gen (
        .ui_clk    (ui_clk),
        .rst_n     (rst_n),
        .load      (start),
        .load_addr (wr_req_addr),
        .step      (cmd_fire),
        .cfg_base  (cfg_base),
        .cfg_top   (cfg_top),
        .addr      (app_addr)
    );

    assign app_cmd       = MIG_CMD_WRITE;
    assign app_wdf_wren  = dat_go;
    assign app_wdf_end   = dat_go;
    assign wr_data_valid = dat_go;
    assign app_wdf_data  = wr_data;
    assign app_wdf_mask  = wr_mask;

endmodule
